mips_fetch_unit: RTL

Parametrised instruction-fetch and next-PC sequencer for the MIPS core. It replaces the combinational PC_REG / plus4Adder / branch, jump and jr mux chain with a handshaked unit. The unit tolerates multi-cycle IMEM, back-pressure from decode/execute and a selectable branch base, and flags fetch faults. It sits between IMEM and MIPS_DECODE. Execute returns redirect controls in the same cycle it accepts an instruction.

---
 rtl/mips_fetch_unit_if.sv | 38 +++
 rtl/mips_fetch_unit.sv | 125 ++++++++++++
 2 files changed

// File: rtl/mips_fetch_unit_if.sv
// Fetch-unit bus: IMEM request/response, decode handshake and execute redirect controls.
//   master : the fetch unit (drives request, held instruction, PCs and fault code)
//   slave  : the environment (IMEM, decode consumer and execute redirect feedback)
interface mips_fetch_unit_if #(
    parameter int unsigned ADDR_WIDTH = 32
);
    logic                  imem_req_out;
    logic [ADDR_WIDTH-1:0] imem_addr_out;
    logic                  imem_ack_in;
    logic [31:0]           imem_rdata_in;
    logic                  instr_valid_out;
    logic                  instr_ready_in;
    logic [31:0]           instr_out;
    logic [ADDR_WIDTH-1:0] pc_out;
    logic [ADDR_WIDTH-1:0] pc4_out;
    logic                  branch_in;
    logic                  bne_in;
    logic                  zero_in;
    logic                  jump_in;
    logic                  jr_in;
    logic [31:0]           imm_ext_in;
    logic [ADDR_WIDTH-1:0] jr_addr_in;
    logic [1:0]            fault_out;

    modport master (
        output imem_req_out, imem_addr_out, instr_valid_out, instr_out, pc_out, pc4_out,
               fault_out,
        input  imem_ack_in, imem_rdata_in, instr_ready_in, branch_in, bne_in, zero_in,
               jump_in, jr_in, imm_ext_in, jr_addr_in
    );

    modport slave (
        input  imem_req_out, imem_addr_out, instr_valid_out, instr_out, pc_out, pc4_out,
               fault_out,
        output imem_ack_in, imem_rdata_in, instr_ready_in, branch_in, bne_in, zero_in,
               jump_in, jr_in, imm_ext_in, jr_addr_in
    );
endinterface

// File: rtl/mips_fetch_unit.sv
// Handshaked instruction-fetch and next-PC sequencer for the MIPS core.
// Fetches from IMEM at the current PC, holds the word for decode until accepted, then
// computes the next PC from the execute redirect controls (jr > jump > branch > PC+4).
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset, returns to IDLE with PC = RESET_PC
//   bus   : mips_fetch_unit_if.master (IMEM request/response, decode handshake,
//           redirect controls, fault code 00 none / 01 IMEM timeout / 10 misaligned jr)
module mips_fetch_unit #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned RESET_PC    = 0,
    parameter bit          BRANCH_BASE = 1'b0,
    parameter int unsigned TIMEOUT     = 0
) (
    input  logic              clk,
    input  logic              reset,
    mips_fetch_unit_if.master bus
);
    localparam logic [ADDR_WIDTH-1:0] ResetPc    = ADDR_WIDTH'(RESET_PC);
    localparam logic [15:0]           TimeoutMax = 16'(TIMEOUT);

    typedef enum logic [1:0] {StIdle, StFetch, StHold, StFault} stateT;

    stateT                 stateQ;
    logic [ADDR_WIDTH-1:0] pcQ;
    logic [31:0]           instrQ;
    logic [15:0]           waitCntQ;
    logic [1:0]            faultQ;
    logic                  reqQ;
    logic                  validQ;

    logic [ADDR_WIDTH-1:0] pc4;
    logic [ADDR_WIDTH-1:0] nextPc;
    logic [31:0]           pc4Ext;
    logic [31:0]           jumpAddr;
    logic [31:0]           immShift;
    logic [ADDR_WIDTH-1:0] branchBase;
    logic                  taken;
    logic                  jrMisaligned;
    logic [15:0]           waitCntInc;
    logic [1:0]            unusedImmTop;

    assign pc4          = pcQ + ADDR_WIDTH'(4);
    assign waitCntInc   = waitCntQ + 16'd1;
    assign unusedImmTop = bus.imm_ext_in[31:30];

    // Only meaningful on the accept cycle; the FSM ignores it everywhere else.
    always_comb begin
        pc4Ext       = 32'(pc4);
        // Zero-extending to 32 bits keeps the region-bit slice legal for ADDR_WIDTH = 28.
        jumpAddr     = {pc4Ext[31:28], instrQ[25:0], 2'b00};
        immShift     = {bus.imm_ext_in[29:0], 2'b00};
        branchBase   = BRANCH_BASE ? pc4 : pcQ;
        taken        = (bus.branch_in & bus.zero_in) | (bus.bne_in & ~bus.zero_in);
        jrMisaligned = bus.jr_in & (bus.jr_addr_in[1:0] != 2'b00);
        nextPc       = pc4;
        if (bus.jr_in) begin
            nextPc = bus.jr_addr_in;
        end else if (bus.jump_in) begin
            nextPc = jumpAddr[ADDR_WIDTH-1:0];
        end else if (taken) begin
            nextPc = branchBase + immShift[ADDR_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateQ   <= StIdle;
            pcQ      <= ResetPc;
            instrQ   <= '0;
            waitCntQ <= '0;
            faultQ   <= 2'b00;
            reqQ     <= 1'b0;
            validQ   <= 1'b0;
        end else begin
            unique case (stateQ)
                StIdle: begin
                    stateQ <= StFetch;
                    reqQ   <= 1'b1;
                end
                StFetch: begin
                    if (bus.imem_ack_in) begin
                        instrQ <= bus.imem_rdata_in;
                        stateQ <= StHold;
                        reqQ   <= 1'b0;
                        validQ <= 1'b1;
                    end else begin
                        waitCntQ <= waitCntInc;
                        if (TIMEOUT != 0 && waitCntInc == TimeoutMax) begin
                            stateQ <= StFault;
                            faultQ <= 2'b01;
                            reqQ   <= 1'b0;
                        end
                    end
                end
                StHold: begin
                    if (bus.instr_ready_in) begin
                        validQ <= 1'b0;
                        if (jrMisaligned) begin
                            // PC deliberately left at the faulting instruction.
                            stateQ <= StFault;
                            faultQ <= 2'b10;
                        end else begin
                            pcQ      <= nextPc;
                            waitCntQ <= '0;
                            stateQ   <= StFetch;
                            reqQ     <= 1'b1;
                        end
                    end
                end
                StFault: begin
                    // Sticky until reset.
                end
            endcase
        end
    end

    assign bus.imem_req_out    = reqQ;
    assign bus.imem_addr_out   = pcQ;
    assign bus.instr_valid_out = validQ;
    assign bus.instr_out       = instrQ;
    assign bus.pc_out          = pcQ;
    assign bus.pc4_out         = pc4;
    assign bus.fault_out       = faultQ;
endmodule
